// File: rtl/tx_ctx_pkt_arbiter_if.sv
// Stream-side bundle of the context-packet arbiter: NUM fifo36 inputs
// merged onto one fifo36 output, plus the one-hot grant indication.
interface tx_ctx_pkt_arbiter_if #(
    parameter int NUM = 4
);
    logic [NUM-1:0][35:0] data_i;
    logic [NUM-1:0]       src_rdy_i;
    logic [NUM-1:0]       dst_rdy_o;
    logic [35:0]          data_o;
    logic                 src_rdy_o;
    logic                 dst_rdy_i;
    logic [NUM-1:0]       grant_o;

    // arbiter side
    modport slave (
        input  data_i, src_rdy_i, dst_rdy_i,
        output dst_rdy_o, data_o, src_rdy_o, grant_o
    );

    // producer/consumer side
    modport master (
        output data_i, src_rdy_i, dst_rdy_i,
        input  dst_rdy_o, data_o, src_rdy_o, grant_o
    );
endinterface

// File: rtl/tx_ctx_pkt_arbiter.sv
// Packet-atomic arbiter for fifo36 context packets: priority class first,
// round-robin inside each class, one arbitration bubble per packet.
// Disabled inputs that are not the current owner are drained and their
// EOF beats counted in a saturating drop counter.
module tx_ctx_pkt_arbiter #(
    parameter int BASE = 0,
    parameter int NUM  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                set_stb,
    input  logic [7:0]          set_addr,
    input  logic [31:0]         set_data,
    tx_ctx_pkt_arbiter_if.slave bus,
    output logic [15:0]         drop_count
);
    localparam int         IW   = $clog2(NUM);
    localparam logic [7:0] ADDR = 8'(BASE);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t         state, state_nxt;
    logic [NUM-1:0] enable, prio;
    logic [IW-1:0]  owner, owner_inc, rr_hi, rr_lo, ptr, pick;
    logic           owner_hi, pick_hi, found;
    logic [NUM-1:0] req, req_hi, cand, drain, drain_eof;
    logic           xfer, eof_xfer;
    logic [3:0]     drops;
    logic [16:0]    drop_sum;
    logic           unused_set;

    // Only the two mask fields of the settings word are meaningful.
    assign unused_set = ^set_data;

    // (p + k) mod NUM, valid for any NUM, not only powers of two.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM) s = s - NUM;
        return IW'(s);
    endfunction

    // Control register: enable and priority masks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable <= '1;
            prio   <= '0;
        end else if (set_stb && set_addr == ADDR) begin
            enable <= set_data[NUM-1:0];
            prio   <= set_data[NUM+15:16];
        end
    end

    // Two-level pick: high class if it has any requester, then first at/after its pointer.
    always_comb begin
        req     = bus.src_rdy_i & enable;
        req_hi  = req & prio;
        pick_hi = |req_hi;
        cand    = pick_hi ? req_hi : req;
        ptr     = pick_hi ? rr_hi : rr_lo;
        pick    = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            if (!found && cand[wrap_add(ptr, k)]) begin
                found = 1'b1;
                pick  = wrap_add(ptr, k);
            end
        end
    end

    // Owner handshake and the EOF beat that releases ownership.
    always_comb begin
        xfer      = (state == GRANT) && bus.src_rdy_i[owner] && bus.dst_rdy_i;
        eof_xfer  = xfer && bus.data_i[owner][33];
        owner_inc = wrap_add(owner, 1);
    end

    // Drain disabled non-owner inputs and count their EOF beats this cycle.
    always_comb begin
        drops = '0;
        for (int n = 0; n < NUM; n++) begin
            drain[n]     = !enable[n] && !(state == GRANT && owner == IW'(n));
            drain_eof[n] = drain[n] && bus.src_rdy_i[n] && bus.data_i[n][33];
            drops        = drops + 4'(drain_eof[n]);
        end
        drop_sum = {1'b0, drop_count} + 17'(drops);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next state: leave IDLE on any request, leave GRANT on the owner's EOF.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req)    state_nxt = GRANT;
            GRANT:   if (eof_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: pass-through for the owner, drain for disabled inputs.
    always_comb begin
        bus.data_o    = '0;
        bus.src_rdy_o = 1'b0;
        bus.dst_rdy_o = drain;
        if (state == GRANT) begin
            bus.data_o           = bus.data_i[owner];
            bus.src_rdy_o        = bus.src_rdy_i[owner];
            bus.dst_rdy_o[owner] = bus.dst_rdy_i;
        end
    end

    // Latch the winner and its class; grant_o is held until its EOF transfers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner       <= '0;
            owner_hi    <= 1'b0;
            bus.grant_o <= '0;
        end else if (state == IDLE && |req) begin
            owner       <= pick;
            owner_hi    <= pick_hi;
            bus.grant_o <= {{(NUM-1){1'b0}}, 1'b1} << pick;
        end else if (eof_xfer) begin
            bus.grant_o <= '0;
        end
    end

    // Per-class round-robin pointers; clear overrides a coincident EOF update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_hi <= '0;
            rr_lo <= '0;
        end else if (clear) begin
            rr_hi <= '0;
            rr_lo <= '0;
        end else if (eof_xfer) begin
            if (owner_hi) rr_hi <= owner_inc;
            else          rr_lo <= owner_inc;
        end
    end

    // Saturating drop counter; clear wins over a same-cycle drained EOF.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         drop_count <= '0;
        else if (clear)       drop_count <= '0;
        else if (drop_sum[16]) drop_count <= 16'hFFFF;
        else                  drop_count <= drop_sum[15:0];
    end
endmodule

// File: tb/tb_tx_ctx_pkt_arbiter.sv
// Bench for tx_ctx_pkt_arbiter: per-input packet queues feed the DUT, the
// merged stream is recorded, and a packet-level scheduling model predicts
// the output order, owners and drop count.
module tb_tx_ctx_pkt_arbiter;
    localparam int NUM = 4;

    logic        clk = 1'b0;
    logic        reset_n, clear, set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [15:0] drop_count;

    tx_ctx_pkt_arbiter_if #(.NUM(NUM)) bif();

    tx_ctx_pkt_arbiter #(.BASE(0), .NUM(NUM)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .set_stb(set_stb),
        .set_addr(set_addr), .set_data(set_data), .bus(bif), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             owner;
        logic [35:0]    d;
        logic [NUM-1:0] g;
    } beat_t;

    int             total = 0, bad = 0, cyc = 0, last_cyc = 0, dst_mode = 0;
    logic [35:0]    srcmem [NUM][256];
    int             head [NUM], tail [NUM];
    beat_t          obs[$], expq[$];
    int             m_hi, m_lo, m_drop;
    logic [NUM-1:0] m_en, m_pr, s_dst, s_grant;

    function automatic int pend();
        for (int n = 0; n < NUM; n++) if (head[n] < tail[n]) return 1;
        return 0;
    endfunction

    task automatic drive_srcs();
        for (int n = 0; n < NUM; n++) begin
            bif.data_i[n]    = (head[n] < tail[n]) ? srcmem[n][head[n]] : 36'h0;
            bif.src_rdy_i[n] = (head[n] < tail[n]);
        end
        case (dst_mode)
            1:       bif.dst_rdy_i = 1'($urandom_range(0, 1));
            2:       bif.dst_rdy_i = (cyc % 2 == 0);
            default: bif.dst_rdy_i = 1'b1;
        endcase
    endtask

    // One clock: sample handshakes mid-cycle, advance queues after the edge.
    task automatic step();
        logic [NUM-1:0] pop;
        beat_t b;
        @(negedge clk);
        pop     = bif.src_rdy_i & bif.dst_rdy_o;
        s_dst   = bif.dst_rdy_o;
        s_grant = bif.grant_o;
        if (bif.src_rdy_o && bif.dst_rdy_i) begin
            b.owner = -1;
            for (int n = 0; n < NUM; n++) if (bif.grant_o[n]) b.owner = n;
            b.d = bif.data_o;
            b.g = bif.grant_o;
            obs.push_back(b);
            last_cyc = cyc;
        end
        @(posedge clk);
        #1;
        for (int n = 0; n < NUM; n++) if (pop[n]) head[n]++;
        cyc++;
        drive_srcs();
    endtask

    task automatic add_pkt(input int n, input int len);
        for (int b = 0; b < len; b++) begin
            srcmem[n][tail[n]] = {2'($urandom), (b == len - 1), (b == 0), 32'($urandom)};
            tail[n]++;
        end
    endtask

    task automatic set_reg(input logic [NUM-1:0] en, input logic [NUM-1:0] pr, input logic [7:0] addr);
        set_stb  = 1'b1;
        set_addr = addr;
        set_data = 32'(en) | (32'(pr) << 16);
        step();
        set_stb  = 1'b0;
        if (addr == 8'd0) begin
            m_en = en;
            m_pr = pr;
        end
    endtask

    task automatic new_test();
        obs.delete();
        expq.delete();
        for (int n = 0; n < NUM; n++) begin
            head[n] = 0;
            tail[n] = 0;
        end
    endtask

    // Packet-level scheduler: drops for disabled inputs, then repeatedly pick
    // a whole packet by class and round-robin pointer over the queued packets.
    task automatic predict(input logic [NUM-1:0] mask);
        int h [NUM];
        logic [NUM-1:0] rq, hi;
        int p, w;
        beat_t b;
        for (int n = 0; n < NUM; n++) begin
            h[n] = head[n];
            if (mask[n] && !m_en[n]) begin
                for (int i = h[n]; i < tail[n]; i++) if (srcmem[n][i][33]) m_drop++;
                h[n] = tail[n];
            end
        end
        for (int it = 0; it < 256; it++) begin
            rq = '0;
            for (int n = 0; n < NUM; n++) rq[n] = mask[n] && m_en[n] && (h[n] < tail[n]);
            if (rq == '0) break;
            hi = rq & m_pr;
            p  = (hi != '0) ? m_hi : m_lo;
            w  = -1;
            for (int k = 0; k < NUM; k++)
                if (w < 0 && ((hi != '0) ? hi[(p + k) % NUM] : rq[(p + k) % NUM])) w = (p + k) % NUM;
            for (int i = 0; i < 64; i++) begin
                b.owner = w;
                b.d     = srcmem[w][h[w]];
                b.g     = NUM'(1) << w;
                expq.push_back(b);
                h[w]++;
                if (b.d[33]) break;
            end
            if (hi != '0) m_hi = (w + 1) % NUM;
            else          m_lo = (w + 1) % NUM;
        end
    endtask

    task automatic run_until_empty(input int budget);
        for (int k = 0; k < budget && pend() != 0; k++) step();
    endtask

    task automatic test_reset();
        total++; if (bif.grant_o !== '0)    begin bad++; $display("FAIL reset_grant got=%h want=0", bif.grant_o); end
        total++; if (bif.dst_rdy_o !== '0)  begin bad++; $display("FAIL reset_dst_rdy got=%h want=0", bif.dst_rdy_o); end
        total++; if (bif.src_rdy_o !== 1'b0) begin bad++; $display("FAIL reset_src_rdy got=%b want=0", bif.src_rdy_o); end
        total++; if (bif.data_o !== '0)     begin bad++; $display("FAIL reset_data got=%h want=0", bif.data_o); end
        total++; if (drop_count !== '0)     begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_count); end
    endtask

    task automatic test_round_robin();
        int t0;
        new_test();
        for (int n = 0; n < NUM; n++) add_pkt(n, 3);
        predict('1);
        drive_srcs();
        t0 = cyc;
        run_until_empty(60);
        total++; if (pend() != 0) begin bad++; $display("FAIL rr_timeout pending inputs remain"); end
        total++; if (obs.size() != expq.size()) begin bad++; $display("FAIL rr_len got=%0d want=%0d", obs.size(), expq.size()); end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            total++;
            if (obs[i].owner !== expq[i].owner || obs[i].d !== expq[i].d || obs[i].g !== expq[i].g) begin
                bad++; $display("FAIL rr_beat%0d got=%0d/%h want=%0d/%h", i, obs[i].owner, obs[i].d, expq[i].owner, expq[i].d);
            end
        end
        total++; if (last_cyc - t0 + 1 != 16) begin bad++; $display("FAIL rr_cycles got=%0d want=16", last_cyc - t0 + 1); end
    endtask

    task automatic test_priority();
        new_test();
        set_reg(4'hF, 4'b1000, 8'd0);
        for (int k = 0; k < 3; k++) begin
            add_pkt(0, 2);
            add_pkt(3, 2);
        end
        predict('1);
        drive_srcs();
        run_until_empty(80);
        total++; if (obs.size() != expq.size()) begin bad++; $display("FAIL prio_len got=%0d want=%0d", obs.size(), expq.size()); end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            total++;
            if (obs[i].owner !== expq[i].owner || obs[i].d !== expq[i].d || obs[i].g !== expq[i].g) begin
                bad++; $display("FAIL prio_beat%0d got=%0d/%h want=%0d/%h", i, obs[i].owner, obs[i].d, expq[i].owner, expq[i].d);
            end
        end
    endtask

    task automatic test_drain();
        new_test();
        set_reg(4'b1110, 4'b0000, 8'd0);
        for (int k = 0; k < 5; k++) add_pkt(0, $urandom_range(1, 3));
        predict('1);
        drive_srcs();
        for (int k = 0; k < 60 && pend() != 0; k++) begin
            step();
            total++; if (s_dst[0] !== 1'b1) begin bad++; $display("FAIL drain_dst_rdy got=%b want=1", s_dst[0]); end
        end
        total++; if (obs.size() != 0) begin bad++; $display("FAIL drain_output got=%0d beats want=0", obs.size()); end
        total++; if (drop_count !== 16'(m_drop)) begin bad++; $display("FAIL drain_count got=%0d want=%0d", drop_count, m_drop); end
    endtask

    task automatic test_clear_mid_packet();
        beat_t b;
        new_test();
        total++; if (drop_count !== 16'(m_drop)) begin bad++; $display("FAIL clr_pre_count got=%0d want=%0d", drop_count, m_drop); end
        add_pkt(2, 5);
        for (int i = 0; i < 5; i++) begin
            b.owner = 2; b.d = srcmem[2][i]; b.g = 4'b0100;
            expq.push_back(b);
        end
        drive_srcs();
        for (int k = 0; k < 20 && obs.size() < 2; k++) step();
        clear = 1'b1;
        add_pkt(1, 3);
        add_pkt(3, 2);
        drive_srcs();
        for (int k = 0; k < 40 && !(obs.size() > 0 && obs[obs.size()-1].owner == 2 && obs[obs.size()-1].d[33]); k++) step();
        clear = 1'b0;
        m_hi = 0; m_lo = 0; m_drop = 0;
        predict(4'b1010);
        run_until_empty(60);
        total++; if (obs.size() != expq.size()) begin bad++; $display("FAIL clr_len got=%0d want=%0d", obs.size(), expq.size()); end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            total++;
            if (obs[i].owner !== expq[i].owner || obs[i].d !== expq[i].d || obs[i].g !== expq[i].g) begin
                bad++; $display("FAIL clr_beat%0d got=%0d/%h want=%0d/%h", i, obs[i].owner, obs[i].d, expq[i].owner, expq[i].d);
            end
        end
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL clr_count got=%0d want=0", drop_count); end
    endtask

    task automatic test_backpressure();
        new_test();
        set_reg(4'hF, 4'h0, 8'd0);
        dst_mode = 2;
        add_pkt(1, 6);
        predict(4'b0010);
        drive_srcs();
        for (int k = 0; k < 20 && obs.size() < 1; k++) step();
        add_pkt(2, 2);
        drive_srcs();
        set_reg(4'hF, 4'b0100, 8'd0);
        predict(4'b0100);
        for (int k = 0; k < 80 && pend() != 0; k++) begin
            step();
            total++;
            if (s_grant == 4'b0010 && s_dst[2] !== 1'b0) begin bad++; $display("FAIL bp_holdoff dst_rdy2 got=%b want=0", s_dst[2]); end
        end
        total++; if (obs.size() != expq.size()) begin bad++; $display("FAIL bp_len got=%0d want=%0d", obs.size(), expq.size()); end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            total++;
            if (obs[i].owner !== expq[i].owner || obs[i].d !== expq[i].d || obs[i].g !== expq[i].g) begin
                bad++; $display("FAIL bp_beat%0d got=%0d/%h want=%0d/%h", i, obs[i].owner, obs[i].d, expq[i].owner, expq[i].d);
            end
        end
        dst_mode = 0;
        set_reg(4'hF, 4'h0, 8'd0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        m_hi = 0; m_lo = 0; m_drop = 0;
    endtask

    task automatic test_async_reset();
        new_test();
        set_reg(4'b0111, 4'b1000, 8'd0);
        add_pkt(0, 8);
        drive_srcs();
        for (int k = 0; k < 20 && obs.size() < 2; k++) step();
        #2 reset_n = 1'b0;
        #1;
        total++; if (bif.grant_o !== '0)    begin bad++; $display("FAIL arst_grant got=%h want=0", bif.grant_o); end
        total++; if (bif.src_rdy_o !== 1'b0) begin bad++; $display("FAIL arst_src_rdy got=%b want=0", bif.src_rdy_o); end
        total++; if (bif.data_o !== '0)     begin bad++; $display("FAIL arst_data got=%h want=0", bif.data_o); end
        total++; if (bif.dst_rdy_o !== '0)  begin bad++; $display("FAIL arst_dst_rdy got=%h want=0", bif.dst_rdy_o); end
        new_test();
        drive_srcs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        m_en = '1; m_pr = '0; m_hi = 0; m_lo = 0; m_drop = 0;
        add_pkt(3, 2);
        add_pkt(0, 2);
        predict('1);
        drive_srcs();
        run_until_empty(40);
        total++; if (obs.size() != expq.size()) begin bad++; $display("FAIL arst_len got=%0d want=%0d", obs.size(), expq.size()); end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            total++;
            if (obs[i].owner !== expq[i].owner || obs[i].d !== expq[i].d || obs[i].g !== expq[i].g) begin
                bad++; $display("FAIL arst_beat%0d got=%0d/%h want=%0d/%h", i, obs[i].owner, obs[i].d, expq[i].owner, expq[i].d);
            end
        end
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL arst_count got=%0d want=0", drop_count); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            new_test();
            set_reg(4'($urandom), 4'($urandom), 8'h5A);
            set_reg(4'($urandom), 4'($urandom), 8'd0);
            for (int n = 0; n < NUM; n++)
                for (int p = $urandom_range(0, 3); p > 0; p--) add_pkt(n, $urandom_range(1, 4));
            predict('1);
            dst_mode = 1;
            drive_srcs();
            run_until_empty(400);
            dst_mode = 0;
            total++; if (pend() != 0) begin bad++; $display("FAIL rnd%0d_timeout pending inputs remain", r); end
            total++; if (obs.size() != expq.size()) begin bad++; $display("FAIL rnd%0d_len got=%0d want=%0d", r, obs.size(), expq.size()); end
            for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
                total++;
                if (obs[i].owner !== expq[i].owner || obs[i].d !== expq[i].d || obs[i].g !== expq[i].g) begin
                    bad++; $display("FAIL rnd%0d_beat%0d got=%0d/%h want=%0d/%h", r, i, obs[i].owner, obs[i].d, expq[i].owner, expq[i].d);
                end
            end
            total++; if (drop_count !== 16'(m_drop)) begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", r, drop_count, m_drop); end
        end
    endtask

    // Sequence of scenarios; model state starts from reset values.
    initial begin
        reset_n = 1'b0; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
        m_en = '1; m_pr = '0; m_hi = 0; m_lo = 0; m_drop = 0;
        new_test();
        drive_srcs();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        test_round_robin();
        test_priority();
        test_drain();
        test_clear_mid_packet();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
